skynet_mul_share_arb: RTL

Round-robin arbiter and pipeline sequencer that time-shares one signed 9-bit x 11-bit multiplier (20-bit signed product) among NUM_REQ requesters. Each requester issues operand pairs over a valid/ready handshake. The block selects one request per cycle, registers the operands, multiplies, and returns the product tagged with the requester index over a backpressured result channel. It sits between the conv-layer PE lanes and the shared DSP48 multiplier.

---
 rtl/skynet_mul_share_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/skynet_mul_share_arb.sv
// Time-shares one signed 9x11 multiplier among NUM_REQ requesters.
// A round-robin arbiter feeds a two-stage pipeline. S1 holds the operands
// and the requester tag. S2 holds the registered product and drives the
// backpressured result channel.
module skynet_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*9-1:0]  req_a,
  input  logic [NUM_REQ*11-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  res_valid,
  output logic [19:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int PTR_SPAN = 2 ** ID_W;

  logic [ID_W-1:0]     rrPtr_q, rrPtr_d;
  logic                s1Valid_q, s1Valid_d;
  logic signed [8:0]   s1A_q, s1A_d;
  logic signed [10:0]  s1B_q, s1B_d;
  logic [ID_W-1:0]     s1Id_q, s1Id_d;
  logic                resValid_q, resValid_d;
  logic signed [19:0]  resData_q, resData_d;
  logic [ID_W-1:0]     resId_q, resId_d;

  logic                s2Load;
  logic                s1En;
  logic                grantFound;
  logic [ID_W-1:0]     grantIdx;
  logic                handshake;
  logic [PTR_SPAN-1:0] validExt;
  logic [ID_W:0]       candSum;
  logic signed [8:0]   selA;
  logic signed [10:0]  selB;
  logic signed [19:0]  product;

  // Widening the valid vector lets a pointer-width index select it safely.
  assign validExt  = PTR_SPAN'(req_valid);
  assign s2Load    = !resValid_q || res_ready;
  assign s1En      = !s1Valid_q || s2Load;
  assign handshake = ap_rst_n && grantFound && s1En;
  assign product   = $signed({{11{s1A_q[8]}}, s1A_q}) * $signed({{9{s1B_q[10]}}, s1B_q});

  // Round-robin search: the first valid requester at or after the pointer, with wrap.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candSum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = {1'b0, rrPtr_q} + (ID_W+1)'(k);
      if (candSum >= (ID_W+1)'(NUM_REQ)) begin
        candSum = candSum - (ID_W+1)'(NUM_REQ);
      end
      if (!grantFound && validExt[candSum[ID_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = candSum[ID_W-1:0];
      end
    end
  end

  // Select the granted requester's operands from the packed buses.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == ID_W'(i)) begin
        selA = req_a[9*i +: 9];
        selB = req_b[11*i +: 11];
      end
    end
  end

  // Only the granted requester sees ready, and only when S1 can take it and reset is released.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = handshake && (grantIdx == ID_W'(i));
    end
  end

  // Next-state logic: S2 drains S1, S1 takes the granted request, and the pointer moves past the winner.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Id_d     = s1Id_q;
    resValid_d = resValid_q;
    resData_d  = resData_q;
    resId_d    = resId_q;
    if (s2Load) begin
      resValid_d = s1Valid_q;
      resData_d  = product;
      resId_d    = s1Id_q;
    end
    if (s1En) begin
      s1Valid_d = handshake;
      if (handshake) begin
        s1A_d   = selA;
        s1B_d   = selB;
        s1Id_d  = grantIdx;
        rrPtr_d = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
      end
    end
  end

  // State registers; reset drops every in-flight operation.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rrPtr_q    <= '0;
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Id_q     <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resId_q    <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Id_q     <= s1Id_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resId_q    <= resId_d;
    end
  end

  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_id    = resId_q;
  assign busy      = s1Valid_q || resValid_q;

endmodule
